// File: rtl/motor_ramp_sequencer_pkg.sv
// Shared definitions for the motor ramp sequencer: duty width, duty ceiling,
// channel state encoding and the per-channel target payload.
package motor_ramp_sequencer_pkg;

  localparam int unsigned DUTY_CYCLE_SIZE = 10;

  // Highest allowed duty is a fixed fraction of full scale (15/16 -> 960 of 1024).
  localparam int unsigned MAX_DUTY_CYCLE_FRAC_NUM = 15;
  localparam int unsigned MAX_DUTY_CYCLE_FRAC_DEN = 16;
  localparam int unsigned MAX_DC =
    ((32'd1 << DUTY_CYCLE_SIZE) * MAX_DUTY_CYCLE_FRAC_NUM) / MAX_DUTY_CYCLE_FRAC_DEN;

  typedef logic [DUTY_CYCLE_SIZE-1:0] duty_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DECEL  = 2'd2,
    ST_SWITCH = 2'd3
  } chan_state_e;

  typedef struct packed {
    logic  dir;
    logic  on;
    duty_t duty;
  } chan_target_t;

  // Build a stored target: off forces duty 0, on clamps duty to MAX_DC.
  function automatic chan_target_t make_target(logic dir, logic on, duty_t duty);
    chan_target_t t;
    t.dir = dir;
    t.on  = on;
    if (!on) begin
      t.duty = '0;
    end else if (duty > duty_t'(MAX_DC)) begin
      t.duty = duty_t'(MAX_DC);
    end else begin
      t.duty = duty;
    end
    return t;
  endfunction

endpackage

// File: rtl/motor_ramp_channel.sv
// One H-bridge channel: stores its target and ramps duty toward it, decelerating
// to zero and holding off for SWITCH_HOLD ticks before any direction change.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   tick              - shared ramp tick, one cycle wide
//   load, load_target - write a new (already clamped) target
//   force_off         - watchdog expiry, sets the target to off/0
//   dir, on, duty     - registered drive to the H-bridge controller
//   busy              - channel is neither IDLE nor settled in RUN
module motor_ramp_channel
  import motor_ramp_sequencer_pkg::*;
#(
  parameter int unsigned RAMP_STEP   = 8,
  parameter int unsigned SWITCH_HOLD = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  chan_target_t load_target,
  input  logic         force_off,
  output logic         dir,
  output logic         on,
  output duty_t        duty,
  output logic         busy
);

  localparam int unsigned HOLD_W = (SWITCH_HOLD > 1) ? $clog2(SWITCH_HOLD) : 1;
  localparam duty_t STEP = duty_t'(RAMP_STEP);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SWITCH_HOLD - 1);

  chan_state_e       state_q, state_d;
  chan_state_e       decel_to;
  chan_target_t      tgt_q, tgt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              dir_d, on_d, busy_d;
  duty_t             duty_d, duty_dn, gap;

  // Target update; watchdog expiry never coincides with an accepted command.
  always_comb begin
    tgt_d = tgt_q;
    if (force_off) begin
      tgt_d = '0;
    end else if (load) begin
      tgt_d = load_target;
    end
  end

  // Next state, ramp and drive outputs; all movement happens on ticks.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    dir_d   = dir;
    duty_d  = duty;
    gap     = '0;
    duty_dn = (duty > STEP) ? duty - STEP : '0;

    // Where a decelerating channel lands once this tick's step is applied.
    if (duty_dn != '0) begin
      decel_to = ST_DECEL;
    end else if (!tgt_q.on) begin
      decel_to = ST_IDLE;
    end else if (tgt_q.dir != dir) begin
      decel_to = ST_SWITCH;
    end else begin
      decel_to = ST_RUN;
    end

    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (tgt_q.on) begin
            state_d = ST_SWITCH;
            hold_d  = '0;
          end
        end
        ST_SWITCH: begin
          if (!tgt_q.on) begin
            state_d = ST_IDLE;
          end else if (hold_q == HOLD_LAST) begin
            state_d = ST_RUN;
            dir_d   = tgt_q.dir;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (!tgt_q.on || (tgt_q.dir != dir)) begin
            // The leaving tick already takes the first deceleration step.
            state_d = decel_to;
            duty_d  = duty_dn;
            hold_d  = '0;
          end else if (duty < tgt_q.duty) begin
            gap    = tgt_q.duty - duty;
            duty_d = duty + ((gap > STEP) ? STEP : gap);
          end else if (duty > tgt_q.duty) begin
            gap    = duty - tgt_q.duty;
            duty_d = duty - ((gap > STEP) ? STEP : gap);
          end
        end
        ST_DECEL: begin
          state_d = decel_to;
          duty_d  = duty_dn;
          hold_d  = '0;
          if (decel_to == ST_RUN) begin
            dir_d = tgt_q.dir;
          end
        end
      endcase
    end

    on_d   = (state_d == ST_RUN) || (state_d == ST_DECEL);
    busy_d = !((state_d == ST_IDLE) ||
               ((state_d == ST_RUN) && tgt_d.on && (tgt_d.dir == dir_d) &&
                (duty_d == tgt_d.duty)));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      hold_q  <= '0;
      dir     <= 1'b0;
      on      <= 1'b0;
      duty    <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
      dir     <= dir_d;
      on      <= on_d;
      duty    <= duty_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Multi-channel motor ramp sequencer: command decode, shared ramp prescaler and
// command watchdog, feeding NUM_MOTORS motor_ramp_channel instances.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   cmd_valid/cmd_ready              - command handshake
//   cmd_motor, cmd_dir, cmd_on,
//   cmd_duty                         - command payload
//   cmd_err                          - one-cycle pulse for an out-of-range channel
//   dir, on, duty_cycle              - per-channel drive (channel i at [i*DCS +: DCS])
//   busy                             - per-channel not IDLE and not settled RUN
//   wd_tripped                       - sticky watchdog flag
module motor_ramp_sequencer
  import motor_ramp_sequencer_pkg::*;
#(
  parameter int unsigned NUM_MOTORS  = 4,
  parameter int unsigned RAMP_DIV    = 50000,
  parameter int unsigned RAMP_STEP   = 8,
  parameter int unsigned SWITCH_HOLD = 4,
  parameter int unsigned WD_CYCLES   = 50000000
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [$clog2(NUM_MOTORS + 1)-1:0]     cmd_motor,
  input  logic                                  cmd_dir,
  input  logic                                  cmd_on,
  input  logic [DUTY_CYCLE_SIZE-1:0]            cmd_duty,
  output logic                                  cmd_err,
  output logic [NUM_MOTORS-1:0]                 dir,
  output logic [NUM_MOTORS-1:0]                 on,
  output logic [NUM_MOTORS*DUTY_CYCLE_SIZE-1:0] duty_cycle,
  output logic [NUM_MOTORS-1:0]                 busy,
  output logic                                  wd_tripped
);

  // Channel index is one bit wider than strictly needed so out-of-range
  // indices such as NUM_MOTORS itself can be expressed and rejected.
  localparam int unsigned MOTOR_W = $clog2(NUM_MOTORS + 1);
  localparam int unsigned DIV_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned WD_W    = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WD_CYCLES - 1);

  logic             rst_q;
  logic [DIV_W-1:0] presc;
  logic             tick;
  logic [WD_W-1:0]  wd_cnt;
  logic             accept_c;
  logic             idx_ok_c;
  logic             wd_expire_c;
  chan_target_t     target_c;

  // Command decode; an accept in the expiry cycle suppresses the trip.
  always_comb begin
    accept_c    = cmd_valid && cmd_ready;
    idx_ok_c    = cmd_motor < MOTOR_W'(NUM_MOTORS);
    wd_expire_c = !accept_c && !wd_tripped && (wd_cnt == WD_LAST);
    target_c    = make_target(cmd_dir, cmd_on, duty_t'(cmd_duty));
  end

  // Ready stays low through reset and for one cycle after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_q     <= 1'b1;
      cmd_ready <= 1'b0;
    end else begin
      rst_q     <= 1'b0;
      cmd_ready <= !rst_q;
    end
  end

  // Ramp prescaler: one registered tick per wrap, shared by all channels.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (presc == DIV_LAST) begin
      presc <= '0;
      tick  <= 1'b1;
    end else begin
      presc <= presc + DIV_W'(1);
      tick  <= 1'b0;
    end
  end

  // Watchdog: any accepted command restarts it; counter parks once tripped.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt     <= '0;
      wd_tripped <= 1'b0;
    end else if (accept_c) begin
      wd_cnt     <= '0;
      wd_tripped <= 1'b0;
    end else if (wd_expire_c) begin
      wd_tripped <= 1'b1;
    end else if (wd_cnt != WD_LAST) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // Out-of-range channel pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= accept_c && !idx_ok_c;
    end
  end

  for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_chan
    logic load_c;

    assign load_c = accept_c && idx_ok_c && (cmd_motor == MOTOR_W'(i));

    motor_ramp_channel #(
      .RAMP_STEP   (RAMP_STEP),
      .SWITCH_HOLD (SWITCH_HOLD)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .load        (load_c),
      .load_target (target_c),
      .force_off   (wd_expire_c),
      .dir         (dir[i]),
      .on          (on[i]),
      .duty        (duty_cycle[i*DUTY_CYCLE_SIZE +: DUTY_CYCLE_SIZE]),
      .busy        (busy[i])
    );
  end

endmodule
